pipe_adder_collector: RTL and testbench

Downstream stage of the 4-slice pipelined adder.
- Tracks which adder issues are valid using a LAT-deep valid delay line. The adder itself carries no valid signal.
- Captures the aligned sum and carry-out into a small FIFO and presents them on a ready/valid output.
- Exerts credit-based back-pressure on the operand source, so a capture can never find the FIFO full.

---
 rtl/pipe_adder_collector_pkg.sv | 22 ++
 rtl/pipe_adder_collector_sync_fifo_rv.sv | 77 +++++++
 rtl/pipe_adder_collector.sv | 95 +++++++++
 tb/tb_pipe_adder_collector.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_collector_pkg.sv
// Shared constants and helpers for the pipelined-adder collector stage.
package pipe_adder_collector_pkg;

   localparam int DEFAULT_H     = 8;
   localparam int DEFAULT_LAT   = 4;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DEFAULT_CW    = 16;

   // One FIFO entry carries the 4*H-bit sum plus the carry-out bit.
   function automatic int entry_width(input int h);
      return 4 * h + 1;
   endfunction

   // Number of bits needed to index v entries (v >= 2).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/pipe_adder_collector_sync_fifo_rv.sv
// Registered first-word-fall-through FIFO. Storage is an array with a
// registered read into a head register, so an entry written at one edge
// becomes visible on the edge after. Occupancy counts the head plus storage.
import pipe_adder_collector_pkg::*;

module sync_fifo_rv #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         pop,
   output logic [W-1:0] rd_data,
   output logic         empty,
   output logic         full
);

   localparam int AW  = clog2(DEPTH);
   localparam int CNW = AW + 1;

   logic [W-1:0]   mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNW-1:0] mem_cnt_reg, count_reg;
   logic [W-1:0]   head_reg;
   logic           head_valid_reg;

   logic do_pop, do_wr, load;

   // A pop frees a slot in the same cycle, so a write while full is accepted
   // when it coincides with a pop. The head refills only from entries that
   // were already stored before this edge (no write-to-head bypass).
   always_comb begin
      do_pop = pop && head_valid_reg;
      do_wr  = wr_en && (!full || do_pop);
      load   = (!head_valid_reg || do_pop) && (mem_cnt_reg != '0);
   end

   assign full    = (count_reg == CNW'(DEPTH));
   assign empty   = !head_valid_reg;
   assign rd_data = head_reg;

   // Storage write port; contents need no reset since pointers gate reads.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_reg] <= wr_data;
   end

   // Registered read into the head register presented on the output.
   always_ff @(posedge clk) begin
      if (!reset) begin
         head_reg       <= '0;
         head_valid_reg <= 1'b0;
      end else if (load) begin
         head_reg       <= mem[rd_ptr_reg];
         head_valid_reg <= 1'b1;
      end else if (do_pop) begin
         head_valid_reg <= 1'b0;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         mem_cnt_reg <= '0;
         count_reg   <= '0;
      end else begin
         wr_ptr_reg  <= wr_ptr_reg + AW'(do_wr);
         rd_ptr_reg  <= rd_ptr_reg + AW'(load);
         mem_cnt_reg <= mem_cnt_reg + CNW'(do_wr) - CNW'(load);
         count_reg   <= count_reg + CNW'(do_wr) - CNW'(do_pop);
      end
   end

endmodule

// File: rtl/pipe_adder_collector.sv
// Collector stage behind a 4-slice pipelined adder: tracks issue validity
// with a delay line, buffers aligned results and throttles issue by credits.
import pipe_adder_collector_pkg::*;

module pipe_adder_collector #(
   parameter int H     = DEFAULT_H,
   parameter int LAT   = DEFAULT_LAT,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CW    = DEFAULT_CW
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [4*H-1:0] sum_in,
   input  logic           cout_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [4*H-1:0] out_sum,
   output logic           out_cout,
   output logic [CW-1:0]  res_count,
   output logic           err_ovf
);

   localparam int EW  = entry_width(H);
   localparam int CRW = clog2(DEPTH) + 1;

   logic           vld_reg [LAT];
   logic [CRW-1:0] credits_reg, credits_next;
   logic [CW-1:0]  res_count_reg;
   logic           err_ovf_reg;
   logic           issue, pop, capture;
   logic           fifo_empty, fifo_full;
   logic [EW-1:0]  head_data;

   // Credits cover every in-flight issue plus every buffered result, so a
   // capture always finds room; ready depends on registered state only.
   always_comb begin
      in_ready     = (credits_reg < CRW'(DEPTH));
      issue        = in_valid && in_ready;
      pop          = out_valid && out_ready;
      capture      = vld_reg[LAT-1];
      credits_next = credits_reg + CRW'(issue) - CRW'(pop);
   end

   // First delay-line stage records whether this cycle's operands were issued.
   always_ff @(posedge clk) begin
      if (!reset) vld_reg[0] <= 1'b0;
      else        vld_reg[0] <= issue;
   end

   generate
      for (genvar gi = 1; gi < LAT; gi++) begin : g_vld
         // Shift the issue marker along in step with the adder pipeline.
         always_ff @(posedge clk) begin
            if (!reset) vld_reg[gi] <= 1'b0;
            else        vld_reg[gi] <= vld_reg[gi-1];
         end
      end
   endgenerate

   // Credit, result-counter and sticky-overflow state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         credits_reg   <= '0;
         res_count_reg <= '0;
         err_ovf_reg   <= 1'b0;
      end else begin
         credits_reg <= credits_next;
         if (pop) res_count_reg <= res_count_reg + CW'(1);
         if (capture && fifo_full && !pop) err_ovf_reg <= 1'b1;
      end
   end

   sync_fifo_rv #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (capture),
      .wr_data ({cout_in, sum_in}),
      .pop     (pop),
      .rd_data (head_data),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign out_valid = !fifo_empty;
   assign out_sum   = head_data[4*H-1:0];
   assign out_cout  = head_data[4*H];
   assign res_count = res_count_reg;
   assign err_ovf   = err_ovf_reg;

endmodule

// File: tb/tb_pipe_adder_collector.sv
// Self-checking bench: drives a behavioural pipelined adder and compares
// the collector against a queue-based reference of issued results.
module tb_pipe_adder_collector;

   localparam int H     = 8;
   localparam int LAT   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready;
   logic [31:0] a_op, b_op;
   logic [32:0] pipe [LAT];
   logic [31:0] sum_in;
   logic        cout_in;

   logic        in_ready, out_valid, out_cout, err_ovf;
   logic [31:0] out_sum;
   logic [15:0] res_count;
   logic        in_ready4, out_valid4, out_cout4, err_ovf4;
   logic [31:0] out_sum4;
   logic [3:0]  res_count4;

   typedef struct {
      logic [32:0] d;
      int          t;
   } item_t;

   item_t q[$];
   int    cyc = 0, pops = 0, issues = 0, acc_seen = 0;
   int    n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   // Adder behaviour: result of operands present at edge e appears at its
   // output after edge e+LAT-1, ready for capture at edge e+LAT.
   always @(posedge clk) begin
      pipe[0] <= {1'b0, a_op} + {1'b0, b_op};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign sum_in  = pipe[LAT-1][31:0];
   assign cout_in = pipe[LAT-1][32];

   pipe_adder_collector #(.H(H), .LAT(LAT), .DEPTH(DEPTH), .CW(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .sum_in(sum_in), .cout_in(cout_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
      .res_count(res_count), .err_ovf(err_ovf));

   pipe_adder_collector #(.H(H), .LAT(LAT), .DEPTH(DEPTH), .CW(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .sum_in(sum_in), .cout_in(cout_in), .out_valid(out_valid4),
      .out_ready(out_ready), .out_sum(out_sum4), .out_cout(out_cout4),
      .res_count(res_count4), .err_ovf(err_ovf4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A result is presented LAT+1 edges after its issue, in issue order.
   function automatic bit exp_valid();
      return (q.size() > 0) && (cyc >= q[0].t + LAT + 1);
   endfunction

   task automatic check_all();
      bit ev;
      ev = exp_valid();
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("out_valid", out_valid, ev);
      chk("out_valid4", out_valid4, ev);
      if (ev) begin
         chk("out_sum", out_sum, q[0].d[31:0]);
         chk("out_cout", out_cout, q[0].d[32]);
         chk("out_sum4", {out_cout4, out_sum4}, q[0].d);
      end
      chk("res_count", res_count, pops % 65536);
      chk("res_count4", res_count4, pops % 16);
      chk("err_ovf", {err_ovf, err_ovf4, in_ready4}, {2'b00, in_ready});
   endtask

   task automatic tick();
      bit          iss, pp;
      logic [32:0] s;
      iss = reset && in_valid && (q.size() < DEPTH);
      pp  = reset && out_ready && exp_valid();
      s   = {1'b0, a_op} + {1'b0, b_op};
      if (in_valid && in_ready) acc_seen++;
      @(posedge clk);
      cyc++;
      if (!reset) begin
         q.delete();
         pops = 0;
      end else begin
         if (pp) begin
            $display("pop %0d: sum=%08h cout=%0b", pops, q[0].d[31:0], q[0].d[32]);
            void'(q.pop_front());
            pops++;
         end
         if (iss) begin
            q.push_back('{d: s, t: cyc});
            issues++;
         end
      end
      #1;
      check_all();
   endtask

   initial begin
      int base, n;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_op = '0; b_op = '0;
      tick(); tick();
      chk("rst_out_sum", {out_cout, out_sum}, 33'h0);
      chk("rst_in_ready", in_ready, 1'b1);
      reset = 1'b1;
      tick();

      // Single issue: 1 + 2 = 3, visible exactly 5 edges after issue.
      a_op = 32'd1; b_op = 32'd2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t1_not_yet", out_valid, 1'b0);
      tick();
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_sum", {out_cout, out_sum}, 33'h0_0000_0003);
      out_ready = 1'b1;
      tick();
      chk("t1_count", res_count, 16'd1);
      out_ready = 1'b0;

      // Carry case.
      a_op = 32'hFFFF_FFFF; b_op = 32'hFFFF_FFFF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("t2_timeout", n < 20, 1'b1);
      chk("t2_sum", out_sum, 32'hFFFF_FFFE);
      chk("t2_cout", out_cout, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Back-pressure: only DEPTH issues accepted while the consumer stalls.
      acc_seen = 0; base = pops;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a_op = $urandom; b_op = $urandom;
         tick();
      end
      chk("t3_accepted", acc_seen, DEPTH);
      chk("t3_ready_low", in_ready, 1'b0);
      chk("t3_head", out_valid, 1'b1);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("t3_drained", res_count, base + DEPTH);
      chk("t3_ready_back", in_ready, 1'b1);

      // Streaming: 100 issues with the consumer always ready.
      base = pops; n = issues;
      in_valid = 1'b1;
      for (int i = 0; i < 400 && issues - n < 100; i++) begin
         a_op = $urandom; b_op = $urandom;
         tick();
         if (issues - n == 100) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      chk("t4_issued", issues - n, 100);
      for (int i = 0; i < 20; i++) tick();
      chk("t4_count", res_count, base + 100);

      // Random traffic on both handshakes.
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
         a_op = $urandom; b_op = $urandom;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();

      // Reset with three results in flight: nothing survives.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin a_op = $urandom; b_op = $urandom; tick(); end
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t5_out_valid", out_valid, 1'b0);
      chk("t5_in_ready", in_ready, 1'b1);
      chk("t5_count", res_count, 16'd0);
      out_ready = 1'b1;
      for (int i = 0; i < LAT + 4; i++) tick();
      chk("t5_no_late", {out_valid, res_count}, 17'd0);

      // 17 pops: the 4-bit counter wraps to 1.
      n = issues; in_valid = 1'b1;
      for (int i = 0; i < 200 && issues - n < 17; i++) begin
         a_op = $urandom; b_op = $urandom;
         tick();
         if (issues - n == 17) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("t6_wrap4", res_count4, 4'd1);
      chk("t6_count16", res_count, 16'd17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
